// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM CPU-port arbiter.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } arb_state_t;

    localparam int REQ_LOADER = 0;
    localparam int REQ_CPU    = 1;
    localparam int REQ_DMA    = 2;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 8;
    localparam int TMO_W  = 10;

endpackage

// File: rtl/sdram_port_arb_if.sv
// Requester-side and sdram-side signals of the CPU-port arbiter.
interface sdram_port_arb_if #(
    parameter int NREQ = 3
);
    import sdram_arb_pkg::*;

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_din;
    logic [NREQ-1:0]        ack;
    logic [DATA_W-1:0]      rdata;
    logic                   timeout_err;
    logic [ADDR_W-1:0]      ram_addr;
    logic [DATA_W-1:0]      ram_din;
    logic                   ram_we;
    logic                   ram_rd;
    logic [DATA_W-1:0]      ram_dout;
    logic                   ram_busy;

    // Arbiter view.
    modport slave (
        input  req, req_we, req_addr, req_din, ram_dout, ram_busy,
        output ack, rdata, timeout_err, ram_addr, ram_din, ram_we, ram_rd
    );

    // Requesters plus sdram view.
    modport master (
        output req, req_we, req_addr, req_din, ram_dout, ram_busy,
        input  ack, rdata, timeout_err, ram_addr, ram_din, ram_we, ram_rd
    );

endinterface

// File: rtl/sdram_port_arb_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    logic [IDX_W-1:0] cand_s;

    // Scan from the farthest candidate back to last+1 so the nearest set request wins.
    always_comb begin
        grant  = '0;
        valid  = 1'b0;
        cand_s = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand_s = IDX_W'((int'(last) + k) % NREQ);
            if (req[cand_s]) begin
                grant = cand_s;
                valid = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arb.sv
// Round-robin arbiter sharing the edge-strobed sdram CPU port between requesters.
// Each access produces a fresh rd/we rising edge and exactly one ack pulse,
// whether the sdram answers with a busy pulse or silently (cache hit).
module sdram_port_arb #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 1023
) (
    input logic             clk,
    input logic             init,
    sdram_port_arb_if.slave bus
);
    import sdram_arb_pkg::*;

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    arb_state_t        state_r;
    arb_state_t        state_s;
    logic [IDX_W-1:0]  grant_r;
    logic [IDX_W-1:0]  last_r;
    logic [IDX_W-1:0]  pick_idx_s;
    logic              pick_valid_s;
    logic              we_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic              wait_done_s;
    logic              wait_abort_s;
    logic [ADDR_W-1:0] addr_a_s [NREQ];
    logic [DATA_W-1:0] din_a_s  [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_split
        assign addr_a_s[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
        assign din_a_s[i]  = bus.req_din[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (bus.req),
        .last  (last_r),
        .grant (pick_idx_s),
        .valid (pick_valid_s)
    );

    // State register.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; WAIT completes on idle busy first, abort only while busy stays high.
    always_comb begin
        state_s      = state_r;
        wait_done_s  = 1'b0;
        wait_abort_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE:  state_s = SETTLE;
            SETTLE: state_s = WAIT;
            WAIT: begin
                if (!bus.ram_busy) begin
                    state_s     = DONE;
                    wait_done_s = 1'b1;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_s      = DONE;
                    wait_abort_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Grant latching, strobes, completion, ack pulse and sticky timeout flag.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            bus.ack         <= '0;
            bus.rdata       <= '0;
            bus.timeout_err <= 1'b0;
            bus.ram_addr    <= '0;
            bus.ram_din     <= '0;
            bus.ram_we      <= 1'b0;
            bus.ram_rd      <= 1'b0;
            grant_r         <= '0;
            last_r          <= IDX_W'(NREQ - 1);
            we_r            <= 1'b0;
            tmo_cnt_r       <= '0;
        end else begin
            bus.ack <= '0;
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        grant_r      <= pick_idx_s;
                        bus.ram_addr <= addr_a_s[pick_idx_s];
                        bus.ram_din  <= din_a_s[pick_idx_s];
                        we_r         <= bus.req_we[pick_idx_s];
                        bus.ram_we   <= bus.req_we[pick_idx_s];
                        bus.ram_rd   <= ~bus.req_we[pick_idx_s];
                    end
                end
                SETTLE: begin
                    tmo_cnt_r <= '0;
                end
                WAIT: begin
                    if (wait_done_s) begin
                        if (!we_r) begin
                            bus.rdata <= bus.ram_dout;
                        end
                        bus.ack[grant_r] <= 1'b1;
                        last_r           <= grant_r;
                        bus.ram_we       <= 1'b0;
                        bus.ram_rd       <= 1'b0;
                    end else if (wait_abort_s) begin
                        bus.timeout_err  <= 1'b1;
                        bus.rdata        <= {DATA_W{1'b1}};
                        bus.ack[grant_r] <= 1'b1;
                        last_r           <= grant_r;
                        bus.ram_we       <= 1'b0;
                        bus.ram_rd       <= 1'b0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 10'd1;
                    end
                end
                default: begin
                    tmo_cnt_r <= tmo_cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Randomized self-checking bench for sdram_port_arb with a cycle-budget reference model.
module tb_sdram_port_arb;
    import sdram_arb_pkg::*;

    localparam int NREQ = 3;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic init;

    sdram_port_arb_if #(.NREQ(NREQ)) bus ();

    sdram_port_arb #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk  (clk),
        .init (init),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Bench sdram: edge-detects strobes, stores writes, raises busy for sd_lat cycles.
    logic [7:0] mem [16];
    int         sd_lat;
    int         sd_cnt;
    logic       sd_prev;
    bit         sd_force_en;
    logic [7:0] sd_force_val;

    always @(posedge clk or posedge init) begin
        if (init) begin
            sd_prev      <= 1'b0;
            sd_cnt       <= 0;
            bus.ram_busy <= 1'b0;
            bus.ram_dout <= 8'h00;
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 37 + 5);
        end else begin
            sd_prev <= bus.ram_we | bus.ram_rd;
            if ((bus.ram_we | bus.ram_rd) && !sd_prev) begin
                if (bus.ram_we) mem[bus.ram_addr[3:0]] <= bus.ram_din;
                else bus.ram_dout <= sd_force_en ? sd_force_val : mem[bus.ram_addr[3:0]];
                sd_cnt       <= sd_lat;
                bus.ram_busy <= (sd_lat > 0);
            end else if (sd_cnt > 1) begin
                sd_cnt <= sd_cnt - 1;
            end else if (sd_cnt == 1) begin
                sd_cnt       <= 0;
                bus.ram_busy <= 1'b0;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model state
    bit         m_active;
    int         m_g;
    bit         m_we;
    int         m_ack;
    bit         m_tmo;
    logic [7:0] m_exp_rd;
    logic [7:0] m_rdata;
    bit         m_terr;
    int         m_last;
    int         m_ready;
    bit         prev_str;
    bit         prev_busy;
    int         busy_fall;
    int         last_start;
    int         last_ack;
    int         last_g;
    int         lat_mode;
    int         rereq_mode;
    bit         rand_en;
    int         grant_log[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_next(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic we, input logic [24:0] a, input logic [7:0] d);
        bus.req[i]            = 1'b1;
        bus.req_we[i]         = we;
        bus.req_addr[i*25 +: 25] = a;
        bus.req_din[i*8 +: 8] = d;
    endtask

    task automatic new_req(input int i);
        logic [24:0] a;
        a = {19'($urandom), 2'(i), 4'($urandom_range(0, 15))};
        set_req(i, 1'($urandom_range(0, 1)), a, 8'($urandom));
    endtask

    // One clock: compare the DUT against the model after the edge, then drive stimulus.
    task automatic step();
        logic [NREQ-1:0] exp_ack;
        logic [24:0]     a;
        bit              obs_start;
        bit              exp_start;
        int              lat;
        @(negedge clk);
        cyc++;
        if (prev_busy && !bus.ram_busy) busy_fall = cyc;
        prev_busy = bus.ram_busy;
        obs_start = (bus.ram_we || bus.ram_rd) && !prev_str;
        exp_start = !m_active && (cyc >= m_ready) && (bus.req != '0);
        check_eq("start", obs_start, exp_start);
        if (exp_start) begin
            m_g  = rr_next(bus.req, m_last);
            m_we = bus.req_we[m_g];
            a    = bus.req_addr[m_g*25 +: 25];
            check_eq("ram_addr", bus.ram_addr, a);
            check_eq("ram_din", bus.ram_din, bus.req_din[m_g*8 +: 8]);
            if (last_ack >= 0) check_eq("strobe_gap_ok", (cyc - last_ack) >= 2, 1);
            if (lat_mode >= 0) lat = lat_mode;
            else lat = ($urandom_range(0, 15) == 0) ? 20 : $urandom_range(0, 10);
            sd_lat = lat;
            m_active   = 1'b1;
            last_start = cyc;
            last_g     = m_g;
            grant_log.push_back(m_g);
            if (lat > TMO) begin
                m_ack    = cyc + TMO + 2;
                m_exp_rd = 8'hFF;
                m_tmo    = 1'b1;
            end else begin
                m_ack    = cyc + ((lat + 2 > 3) ? lat + 2 : 3);
                m_exp_rd = m_we ? m_rdata : (sd_force_en ? sd_force_val : mem[a[3:0]]);
                m_tmo    = 1'b0;
            end
        end
        check_eq("ram_rd", bus.ram_rd, m_active && !m_we && cyc < m_ack);
        check_eq("ram_we", bus.ram_we, m_active && m_we && cyc < m_ack);
        exp_ack = '0;
        if (m_active && cyc == m_ack) begin
            exp_ack[m_g] = 1'b1;
            m_active = 1'b0;
            m_last   = m_g;
            m_ready  = cyc + 2;
            m_rdata  = m_exp_rd;
            m_terr   = m_terr | m_tmo;
            last_ack = cyc;
            if (bus.req[m_g]) begin
                if (rereq_mode == 0) bus.req[m_g] = 1'b0;
                else if (rereq_mode == 2) begin
                    case ($urandom_range(0, 2))
                        0:       bus.req[m_g] = 1'b1;
                        1:       new_req(m_g);
                        default: bus.req[m_g] = 1'b0;
                    endcase
                end
            end
        end
        check_eq("ack", bus.ack, exp_ack);
        check_eq("rdata", bus.rdata, m_rdata);
        check_eq("timeout_err", bus.timeout_err, m_terr);
        prev_str = bus.ram_we || bus.ram_rd;
        if (rand_en) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i]) begin
                    if ($urandom_range(0, 3) == 0) new_req(i);
                end else if ($urandom_range(0, 31) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((m_active || bus.req != '0) && n < budget);
        check_eq("idle_reached", {m_active, |bus.req}, 2'b00);
    endtask

    // Assert init at a negedge, check reset values at once, then release.
    task automatic apply_init(input int ncyc);
        init    = 1'b1;
        bus.req = '0;
        #1;
        check_eq("rst_ack", bus.ack, 0);
        check_eq("rst_rdata", bus.rdata, 0);
        check_eq("rst_ram_we", bus.ram_we, 0);
        check_eq("rst_ram_rd", bus.ram_rd, 0);
        check_eq("rst_ram_addr", bus.ram_addr, 0);
        check_eq("rst_ram_din", bus.ram_din, 0);
        check_eq("rst_timeout_err", bus.timeout_err, 0);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            cyc++;
        end
        init      = 1'b0;
        m_active  = 1'b0;
        m_last    = NREQ - 1;
        m_ready   = cyc + 1;
        m_rdata   = 8'h00;
        m_terr    = 1'b0;
        prev_str  = 1'b0;
        prev_busy = 1'b0;
        last_ack  = -1;
    endtask

    initial begin
        int n;
        bus.req      = '0;
        bus.req_we   = '0;
        bus.req_addr = '0;
        bus.req_din  = '0;
        lat_mode     = 2;
        rereq_mode   = 0;
        rand_en      = 1'b0;
        sd_force_en  = 1'b0;
        sd_force_val = 8'h00;
        busy_fall    = -1;
        apply_init(3);

        // all three reading: grants 0,1,2,0,1,2
        rereq_mode = 1;
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, {19'h0, 2'(i), 4'(i)}, 8'(i));
        n = 0;
        while (grant_log.size() < 6 && n < 200) begin
            step();
            n++;
        end
        bus.req    = '0;
        rereq_mode = 0;
        run_idle(100);
        check_eq("rr_count", grant_log.size(), 6);
        foreach (grant_log[i]) check_eq("rr_order", grant_log[i], i % NREQ);

        // cache hit: CPU read, busy never rises
        lat_mode     = 0;
        sd_force_en  = 1'b1;
        sd_force_val = 8'h3C;
        set_req(REQ_CPU, 1'b0, 25'h0000123, 8'h00);
        run_idle(50);
        check_eq("hit_latency", last_ack - last_start, 3);
        check_eq("hit_rdata", bus.rdata, 8'h3C);
        check_eq("hit_grant", last_g, REQ_CPU);

        // miss: busy for 6 cycles
        lat_mode     = 6;
        sd_force_val = 8'h5A;
        set_req(REQ_CPU, 1'b0, 25'h0000456, 8'h00);
        run_idle(50);
        check_eq("miss_ack_after_busy", last_ack - busy_fall, 1);
        check_eq("miss_rdata", bus.rdata, 8'h5A);

        // loader write then CPU read of the same address
        sd_force_en = 1'b0;
        lat_mode    = 3;
        set_req(REQ_LOADER, 1'b1, 25'h0004001, 8'hA5);
        run_idle(50);
        check_eq("wr_grant", last_g, REQ_LOADER);
        check_eq("wr_rdata_held", bus.rdata, 8'h5A);
        set_req(REQ_CPU, 1'b0, 25'h0004001, 8'h00);
        run_idle(50);
        check_eq("rd_after_wr", bus.rdata, 8'hA5);

        // busy stuck high: abort after TMO wait cycles
        lat_mode = 40;
        set_req(REQ_DMA, 1'b0, 25'h0000777, 8'h00);
        run_idle(60);
        check_eq("tmo_latency", last_ack - last_start, TMO + 2);
        check_eq("tmo_rdata", bus.rdata, 8'hFF);
        for (int i = 0; i < 30; i++) step();
        check_eq("tmo_sticky", bus.timeout_err, 1);

        // init in the middle of WAIT: no ack, next request served normally
        lat_mode = 8;
        set_req(REQ_CPU, 1'b0, 25'h0000321, 8'h00);
        n = 0;
        do begin
            step();
            n++;
        end while (!(m_active && cyc >= last_start + 4) && n < 50);
        check_eq("in_wait_before_init", m_active, 1);
        apply_init(2);
        for (int i = 0; i < 12; i++) step();
        lat_mode = 2;
        set_req(REQ_CPU, 1'b0, 25'h0000002, 8'h00);
        run_idle(50);
        check_eq("post_init_grant", last_g, REQ_CPU);
        check_eq("post_init_rdata", bus.rdata, mem[2]);

        // randomized traffic
        lat_mode   = -1;
        rereq_mode = 2;
        rand_en    = 1'b1;
        for (int i = 0; i < 3000; i++) step();
        rand_en    = 1'b0;
        rereq_mode = 0;
        run_idle(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
